// File: rtl/inertial_sequencer.sv
// IMU command sequencer: configures the IMU after reset, then reads pitch rate and Z acceleration
// over SPI on every data-ready interrupt and presents both words with a one-cycle vld strobe.
module inertial_sequencer #(
  parameter int INIT_WAIT = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [7:0]  resp,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  localparam int CW = (INIT_WAIT > 2) ? $clog2(INIT_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(INIT_WAIT - 1);

  typedef enum logic [3:0] {
    ST_WAIT, ST_CFG0, ST_CFG1, ST_CFG2, ST_CFG3,
    ST_IDLE, ST_RPL, ST_RPH, ST_RAL, ST_RAH
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_int_meta;
  logic          r_int_s;
  logic [7:0]    r_pl;
  logic [7:0]    r_ph;
  logic [7:0]    r_al;
  logic          w_snd_next;
  logic          w_vld_next;
  logic [15:0]   w_cmd_next;

  function automatic logic [15:0] state_cmd(input state_t s);
    logic [15:0] c;
    c = 16'h0000;
    case (s)
      ST_CFG0: c = 16'h0D02;
      ST_CFG1: c = 16'h1053;
      ST_CFG2: c = 16'h1150;
      ST_CFG3: c = 16'h1460;
      ST_RPL:  c = 16'hA200;
      ST_RPH:  c = 16'hA300;
      ST_RAL:  c = 16'hAC00;
      ST_RAH:  c = 16'hAD00;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_meta <= 1'b0;
      r_int_s    <= 1'b0;
    end else begin
      r_int_meta <= INT;
      r_int_s    <= r_int_meta;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_snd_next   = 1'b0;
    w_vld_next   = 1'b0;
    w_cmd_next   = cmd;
    unique case (r_state)
      ST_WAIT: begin
        if (r_cnt == WAIT_LAST) w_state_next = ST_CFG0;
        else                    w_cnt_next   = r_cnt + 1'b1;
      end
      ST_CFG0: if (done) w_state_next = ST_CFG1;
      ST_CFG1: if (done) w_state_next = ST_CFG2;
      ST_CFG2: if (done) w_state_next = ST_CFG3;
      ST_CFG3: if (done) w_state_next = ST_IDLE;
      ST_IDLE: if (r_int_s) w_state_next = ST_RPL;
      ST_RPL:  if (done) w_state_next = ST_RPH;
      ST_RPH:  if (done) w_state_next = ST_RAL;
      ST_RAL:  if (done) w_state_next = ST_RAH;
      ST_RAH: begin
        if (done) begin
          w_state_next = ST_IDLE;
          w_vld_next   = 1'b1;
        end
      end
      default: w_state_next = ST_WAIT;
    endcase
    // snd and cmd are registered so the request is issued on the first cycle of each transaction state
    if ((w_state_next != r_state) && (w_state_next != ST_WAIT) && (w_state_next != ST_IDLE)) begin
      w_snd_next = 1'b1;
      w_cmd_next = state_cmd(w_state_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
      r_pl    <= 8'h00;
      r_ph    <= 8'h00;
      r_al    <= 8'h00;
      snd     <= 1'b0;
      cmd     <= 16'h0000;
      vld     <= 1'b0;
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      snd     <= w_snd_next;
      cmd     <= w_cmd_next;
      vld     <= w_vld_next;
      if (done && (r_state == ST_RPL)) r_pl <= resp;
      if (done && (r_state == ST_RPH)) r_ph <= resp;
      if (done && (r_state == ST_RAL)) r_al <= resp;
      // Both words are published together from the final byte so the integrator never sees a torn pair
      if (w_vld_next) begin
        ptch_rt <= {r_ph, r_pl};
        AZ      <= {resp, r_al};
      end
    end
  end

endmodule

// File: tb/tb_inertial_sequencer.sv
// Scoreboard bench for inertial_sequencer: an SPI responder answers each snd after 5 cycles
// while expected commands and output words are queued by the stimulus and popped as the DUT emits them.
module tb_inertial_sequencer;

  localparam int INIT_WAIT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        snd;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;

  inertial_sequencer #(.INIT_WAIT(INIT_WAIT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .snd     (snd),
    .cmd     (cmd),
    .done    (done),
    .resp    (resp),
    .ptch_rt (ptch_rt),
    .AZ      (AZ),
    .vld     (vld)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] exp_cmd_q[$];
  logic [7:0]  resp_q[$];
  logic [31:0] exp_out_q[$];

  int          pend = 0;
  logic [7:0]  pend_byte = 8'h00;
  bit          spur_req = 0;
  int          last_done_cyc = -100;
  int          rel_cyc = 0;
  int          int_cyc = 0;
  int          vld_cyc = 0;
  int          burst_cyc = 0;
  int          snd_count = 0;
  int          vld_count = 0;
  bit          first_snd_pending = 0;
  bit          int_pending = 0;
  bit          prev_snd = 0;
  bit          prev_vld = 0;
  bit          have_prev = 0;
  logic [15:0] prev_cmd = 16'h0000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // SPI responder and output monitor
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          done = 1'b1;
          resp = pend_byte;
          last_done_cyc = cyc;
        end
      end else if (spur_req) begin
        done = 1'b1;
        resp = 8'hEE;
        spur_req = 0;
      end
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 0;
        prev_snd = 0;
        prev_vld = 0;
      end else begin
        if (snd) begin
          snd_count++;
          check_val("snd_vld_excl", 32'(vld), 0);
          check_val("snd_width", 32'(prev_snd), 0);
          if (pend > 0) check_val("snd_overlap", pend, 0);
          if (exp_cmd_q.size() == 0) check_val("unexpected_snd", 32'(snd), 0);
          else check_val("cmd", 32'(cmd), 32'(exp_cmd_q.pop_front()));
          if (first_snd_pending) begin
            check_val("init_wait", cyc - rel_cyc, INIT_WAIT);
            first_snd_pending = 0;
          end
          if (int_pending) begin
            check_val("int_to_snd", cyc - int_cyc, 3);
            int_pending = 0;
          end
          if (have_prev && prev_cmd != 16'h1460 && prev_cmd != 16'hAD00)
            check_val("snd_after_done", cyc - last_done_cyc, 1);
          if (cmd == 16'hA200) burst_cyc = cyc;
          have_prev = 1;
          prev_cmd = cmd;
          pend = 5;
          pend_byte = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
          $display("cycle %0d: snd cmd=0x%04h reply=0x%02h", cyc, cmd, pend_byte);
        end
        if (vld) begin
          vld_count++;
          vld_cyc = cyc;
          check_val("vld_width", 32'(prev_vld), 0);
          if (exp_out_q.size() == 0) check_val("unexpected_vld", 32'(vld), 0);
          else check_val("vld_data", {ptch_rt, AZ}, exp_out_q.pop_front());
          $display("cycle %0d: vld ptch_rt=0x%04h AZ=0x%04h", cyc, ptch_rt, AZ);
        end
        prev_snd = snd;
        prev_vld = vld;
      end
    end
  end

  task automatic push_init();
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1053);
    exp_cmd_q.push_back(16'h1150);
    exp_cmd_q.push_back(16'h1460);
  endtask

  task automatic push_burst(input logic [7:0] pl, input logic [7:0] ph,
                            input logic [7:0] al, input logic [7:0] ah);
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hAC00);
    exp_cmd_q.push_back(16'hAD00);
    resp_q.push_back(pl);
    resp_q.push_back(ph);
    resp_q.push_back(al);
    resp_q.push_back(ah);
    exp_out_q.push_back({ph, pl, ah, al});
  endtask

  task automatic raise_int(input int hold);
    @(posedge clk); #1;
    INT = 1'b1;
    int_cyc = cyc;
    int_pending = 1;
    repeat (hold) @(posedge clk);
    #1;
    INT = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_cmd_q.size() != 0 || exp_out_q.size() != 0 || pend != 0) && n < budget);
    check_val(tag, 32'(exp_cmd_q.size() + exp_out_q.size()), 0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
    first_snd_pending = 1;
  endtask

  initial begin
    int s;
    int v;
    int v1;
    int n;

    repeat (3) @(negedge clk);
    check_val("rst_snd", 32'(snd), 0);
    check_val("rst_cmd", 32'(cmd), 0);
    check_val("rst_vld", 32'(vld), 0);
    check_val("rst_ptch", 32'(ptch_rt), 0);
    check_val("rst_az", 32'(AZ), 0);

    push_init();
    release_reset();
    wait_drain("init_drain", 300);
    check_val("init_seen", 32'(first_snd_pending), 0);

    s = snd_count;
    repeat (20) @(negedge clk);
    check_val("idle_no_snd", snd_count - s, 0);
    check_val("pre_ptch", 32'(ptch_rt), 0);
    check_val("pre_az", 32'(AZ), 0);

    // Burst 1: positive data
    push_burst(8'h34, 8'h12, 8'h78, 8'h56);
    raise_int(5);
    wait_drain("burst1_drain", 200);

    // Burst 2: negative data, with an INT pulse during RPH that must be ignored
    push_burst(8'h00, 8'h80, 8'hFF, 8'hFF);
    raise_int(5);
    repeat (5) @(posedge clk);
    #1 INT = 1'b1;
    repeat (2) @(posedge clk);
    #1 INT = 1'b0;
    wait_drain("burst2_drain", 200);
    s = snd_count;
    repeat (20) @(negedge clk);
    check_val("rph_int_ignored", snd_count - s, 0);

    // INT held high: two back-to-back bursts
    push_burst(8'hAB, 8'hCD, 8'hEF, 8'h01);
    push_burst(8'h11, 8'h22, 8'h33, 8'h44);
    v = vld_count;
    @(posedge clk); #1;
    INT = 1'b1;
    int_cyc = cyc;
    int_pending = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (vld_count == v && n < 200);
    check_val("hold_first_vld", vld_count - v, 1);
    v1 = vld_cyc;
    @(posedge clk); #1;
    INT = 1'b0;
    wait_drain("hold_drain", 200);
    check_val("b2b_gap", burst_cyc - v1, 1);

    // Spurious done while idle
    s = snd_count;
    v = vld_count;
    spur_req = 1;
    repeat (10) @(negedge clk);
    check_val("spur_no_snd", snd_count - s, 0);
    check_val("spur_no_vld", vld_count - v, 0);
    check_val("spur_hold", {ptch_rt, AZ}, 32'h22114433);

    // Reset during RAL aborts the burst and re-runs init
    exp_cmd_q.push_back(16'hA200);
    exp_cmd_q.push_back(16'hA300);
    exp_cmd_q.push_back(16'hAC00);
    resp_q.push_back(8'h01);
    resp_q.push_back(8'h02);
    resp_q.push_back(8'h03);
    raise_int(5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(have_prev && prev_cmd == 16'hAC00) && n < 100);
    check_val("reach_ral", 32'(prev_cmd), 32'h0000AC00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_vld", 32'(vld), 0);
    check_val("async_rst_snd", 32'(snd), 0);
    check_val("async_rst_cmd", 32'(cmd), 0);
    check_val("async_rst_ptch", 32'(ptch_rt), 0);
    check_val("async_rst_az", 32'(AZ), 0);
    v = vld_count;
    resp_q.delete();
    repeat (3) @(negedge clk);
    push_init();
    release_reset();
    wait_drain("reinit_drain", 300);
    check_val("reinit_seen", 32'(first_snd_pending), 0);
    repeat (10) @(negedge clk);
    check_val("abort_no_vld", vld_count - v, 0);

    push_burst(8'h9A, 8'h78, 8'hBC, 8'hDE);
    raise_int(4);
    wait_drain("post_reset_drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/inertial_sequencer.md
# inertial_sequencer

Command sequencer between the SPI master and the pitch integrator/fusion datapath. After reset it configures the 6-axis IMU over SPI, then services each IMU data-ready interrupt by reading the pitch-rate and Z-acceleration register pairs. It assembles the bytes into signed 16-bit words and presents them with a one-cycle `vld` strobe, which is the integrator's update enable.

## Interface
- `INIT_WAIT`, default 65536: clk cycles between reset release and the first init command. The minimum legal value is 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `INT`  in  1  IMU data-ready, asynchronous, active-high level.
- `snd`  out  1  one-cycle request that starts an SPI transaction.
- `cmd`  out  16  SPI command word. Bits [15:8] are address/opcode with bit 15 as the read flag; bits [7:0] are write data.
- `done`  in  1  one-cycle pulse from the SPI master when the transaction completes.
- `resp`  in  8  SPI read byte, valid in the `done` cycle.
- `ptch_rt`  out  16  signed gyro pitch rate, raw.
- `AZ`  out  16  signed Z acceleration, raw.
- `vld`  out  1  one-cycle strobe: `ptch_rt`/`AZ` were updated this cycle.

## Operation
- `INT` passes through a 2-flop synchronizer (`INT_s`) before the FSM uses it.
- FSM states and their commands:
  - `WAIT`: count `INIT_WAIT` cycles.
  - `CFG0` sends 0x0D02 (data-ready interrupt enable).
  - `CFG1` sends 0x1053 (accel ODR/range).
  - `CFG2` sends 0x1150 (gyro ODR/range).
  - `CFG3` sends 0x1460 (rounding on).
  - `IDLE`: wait for `INT_s`.
  - `RPL` sends 0xA2xx (pitch rate low byte).
  - `RPH` sends 0xA3xx (pitch rate high byte).
  - `RAL` sends 0xACxx (AZ low byte).
  - `RAH` sends 0xADxx (AZ high byte).
  - For reads, `cmd[7:0]` = 0x00.
- Each CFG/R state runs one SPI transaction:
  - On the entry cycle, drive `cmd` and pulse `snd` for 1 cycle.
  - Hold `cmd` stable until `done`.
  - On `done`, advance to the next state.
- Transitions:
  - `WAIT` goes to `CFG0` when the counter reaches `INIT_WAIT`-1.
  - `CFG3` goes to `IDLE` on `done`.
  - `IDLE` goes to `RPL` when `INT_s`=1.
  - `RAH` goes to `IDLE` on `done`.
- Read bytes are captured in `done` cycles: `RPL` gives PL, `RPH` gives PH, `RAL` gives AL, `RAH` gives AH.
- Outputs are updated together, never partially: `ptch_rt` = {PH,PL} and `AZ` = {AH,AL}.
- `INT` is level-sensitive and is sampled only in `IDLE`. Activity on `INT` during CFG or R states is ignored.
- If `INT_s` is still high on return to `IDLE`, a new read burst starts on the next cycle.
- `done` arriving while no transaction is outstanding (`WAIT`, `IDLE`) is ignored.
- The block performs no arithmetic or offset removal; bias compensation belongs to the integrator.

## Timing
- Reset values: `snd`=0, `cmd`=0x0000, `vld`=0, `ptch_rt`=0x0000, `AZ`=0x0000. The FSM resets to `WAIT` and the counter to 0.
- First `snd` is asserted exactly `INIT_WAIT` cycles after the first clk edge with `rst_n` high.
- `snd` follows `done` by exactly 1 cycle between consecutive transactions, with no idle gap.
- `snd` rises one cycle after the `IDLE` cycle in which `INT_s` is seen high. `INT` to first `snd` is 3 cycles: synchronizer plus FSM.
- `vld`, `ptch_rt` and `AZ` update on the edge after the `RAH` `done` cycle. `vld` is high for exactly 1 cycle.
- `snd` and `vld` are never high in the same cycle. `snd` is never reasserted before `done` of the current transaction.
- Reset mid-operation:
  - All outputs return to reset values immediately, asynchronously.
  - The partially captured bytes are discarded.
  - The full init sequence is re-run.

## Test plan
- Reset, `INIT_WAIT`=16 -> `snd` stays low for 16 cycles, then pulses once with `cmd`=0x0D02.
- Answer each init transaction with `done` 5 cycles after `snd` -> `cmd` sequence is 0x0D02, 0x1053, 0x1150, 0x1460, each `snd` 1 cycle after the prior `done`; FSM then idles with no `snd`.
- Raise `INT`; return `resp` 0x34, 0x12, 0x78, 0x56 -> commands 0xA200, 0xA300, 0xAC00, 0xAD00 in order; then `vld` for 1 cycle with `ptch_rt`=0x1234, `AZ`=0x5678, both at 0 beforehand.
- Negative data: `resp` 0x00, 0x80, 0xFF, 0xFF -> `ptch_rt`=0x8000, `AZ`=0xFFFF. Pulse `INT` during `RPH` -> no extra burst after `vld`. Hold `INT` high -> back-to-back bursts.
- Assert `rst_n` low during `RAL` -> `vld`/outputs 0 immediately. After release, `WAIT` plus the full init sequence repeats, with no `vld` from the aborted burst.
- Spurious `done` in `IDLE` -> no state change, no `snd`, no `vld`.
